// File: rtl/gaus_pkg.sv
// Shared constants for the Gaussian 5x3 smoothing stage: pixel width and
// separable kernel weights [1 4 6 4 1] x [1 2 1], normalised by 64.
package gaus_pkg;
  localparam int PIXW   = 16;
  localparam int KV [5] = '{1, 4, 6, 4, 1};
  localparam int KH [3] = '{1, 2, 1};
  localparam int KSHIFT = 6;
  localparam int KROUND = 32;
  localparam int KBITS  = 4;  // weight bits scanned when building shift-add trees
endpackage

// File: rtl/gaus_window_conv_if.sv
// Window-in / pixel-out bundle between the shift buffer, the smoother and its consumer.
interface gaus_window_conv_if
  import gaus_pkg::*;
#(
  parameter int PIXW = gaus_pkg::PIXW,
  parameter int CNTW = 24
);
  logic                 winValid;
  logic [3*PIXW-1:0]    gausShiftOutA;
  logic [3*PIXW-1:0]    gausShiftOutB;
  logic [3*PIXW-1:0]    gausShiftOutC;
  logic [3*PIXW-1:0]    gausShiftOutD;
  logic [3*PIXW-1:0]    gausShiftOutE;
  logic [PIXW-1:0]      pixOut;
  logic                 pixValid;
  logic [CNTW-1:0]      outCount;
  logic                 frameDone;

  modport master (
    output winValid, gausShiftOutA, gausShiftOutB, gausShiftOutC,
           gausShiftOutD, gausShiftOutE,
    input  pixOut, pixValid, outCount, frameDone
  );

  modport slave (
    input  winValid, gausShiftOutA, gausShiftOutB, gausShiftOutC,
           gausShiftOutD, gausShiftOutE,
    output pixOut, pixValid, outCount, frameDone
  );
endinterface

// File: rtl/gaus_vtap5.sv
// Vertical 5-tap column sum A + 4B + 6C + 4D + E built from shifts and adds,
// registered; the register only loads on a valid beat.
module gaus_vtap5
  import gaus_pkg::*;
#(
  parameter int PIXW = gaus_pkg::PIXW
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_en,
  input  logic [4:0][PIXW-1:0]  i_px,   // [0]=row A .. [4]=row E
  output logic [PIXW+3:0]       o_v
);
  localparam int VW = PIXW + 4;

  logic [VW-1:0] w_sum;

  always_comb begin
    w_sum = '0;
    for (int r = 0; r < 5; r++)
      for (int b = 0; b < KBITS; b++)
        if (KV[r][b]) w_sum = w_sum + (VW'(i_px[r]) << b);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    o_v <= '0;
    else if (i_en) o_v <= w_sum;
  end
endmodule

// File: rtl/gaus_window_conv.sv
// 3-stage Gaussian smoother: vertical taps, horizontal [1 2 1] sum, round/shift.
// Tracks line position to drop warm-up beats and counts pixels within a frame.
module gaus_window_conv
  import gaus_pkg::*;
#(
  parameter int PIXW      = gaus_pkg::PIXW,
  parameter int LINEWIDTH = 2048,
  parameter int SKIP      = 2,
  parameter int FRAMEPIX  = 4194304,
  parameter int CNTW      = 24
) (
  input  logic               clk,
  input  logic               reset,
  gaus_window_conv_if.slave  bus
);
  localparam int VW     = PIXW + 4;
  localparam int HW     = PIXW + 6;
  localparam int CW     = (LINEWIDTH > 1) ? $clog2(LINEWIDTH) : 1;
  localparam int STAGES = 3;

  logic [2:0][4:0][PIXW-1:0] w_col_px;
  logic [2:0][VW-1:0]        w_v;
  logic [HW-1:0]             w_h, r_h;
  logic [CW-1:0]             r_colCnt, w_col;
  logic                      w_acc;
  logic [STAGES:1]           r_vld_pipe;
  logic [CNTW-1:0]           w_cnt_next;

  // Column c sits at slice bits [(2-c)*PIXW +: PIXW]; col0 is the oldest.
  for (genvar c = 0; c < 3; c++) begin : g_col
    assign w_col_px[c] = {bus.gausShiftOutE[(2-c)*PIXW +: PIXW],
                          bus.gausShiftOutD[(2-c)*PIXW +: PIXW],
                          bus.gausShiftOutC[(2-c)*PIXW +: PIXW],
                          bus.gausShiftOutB[(2-c)*PIXW +: PIXW],
                          bus.gausShiftOutA[(2-c)*PIXW +: PIXW]};

    gaus_vtap5 #(.PIXW(PIXW)) u_vtap (
      .clk   (clk),
      .reset (reset),
      .i_en  (w_acc),
      .i_px  (w_col_px[c]),
      .o_v   (w_v[c])
    );
  end

  // A beat landing on the frameDone cycle belongs to the new frame, line position 0.
  assign w_col = bus.frameDone ? '0 : r_colCnt;
  assign w_acc = bus.winValid && (w_col >= CW'(SKIP));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            r_colCnt <= '0;
    else if (bus.winValid) r_colCnt <= (w_col == CW'(LINEWIDTH-1)) ? '0 : w_col + CW'(1);
    else                   r_colCnt <= w_col;
  end

  always_comb begin
    w_h = '0;
    for (int c = 0; c < 3; c++)
      for (int b = 0; b < KBITS; b++)
        if (KH[c][b]) w_h = w_h + (HW'(w_v[c]) << b);
  end

  // outCount shows the index of the pixel on pixOut and steps once it has gone out.
  always_comb begin
    w_cnt_next = bus.outCount;
    if (bus.pixValid)
      w_cnt_next = (bus.outCount == CNTW'(FRAMEPIX-1)) ? '0 : bus.outCount + CNTW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vld_pipe    <= '0;
      r_h           <= '0;
      bus.pixOut    <= '0;
      bus.pixValid  <= 1'b0;
      bus.outCount  <= '0;
      bus.frameDone <= 1'b0;
    end else begin
      r_vld_pipe    <= {r_vld_pipe[STAGES-1:1], w_acc};
      if (r_vld_pipe[1]) r_h <= w_h;
      if (r_vld_pipe[2]) bus.pixOut <= PIXW'((r_h + HW'(KROUND)) >> KSHIFT);
      bus.pixValid  <= r_vld_pipe[2];
      bus.outCount  <= w_cnt_next;
      bus.frameDone <= r_vld_pipe[2] && (w_cnt_next == CNTW'(FRAMEPIX-1));
    end
  end
endmodule

// File: tb/tb_gaus_window_conv.sv
// Directed bench for gaus_window_conv with LINEWIDTH=8, SKIP=2, FRAMEPIX=12.
module tb_gaus_window_conv;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  gaus_window_conv_if #(.PIXW(16), .CNTW(24)) bus ();

  gaus_window_conv #(
    .PIXW(16), .LINEWIDTH(8), .SKIP(2), .FRAMEPIX(12), .CNTW(24)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  int n_assert = 0;
  int n_fail   = 0;
  int exp_cnt  = 0;
  bit          d_v [3];
  logic [15:0] d_p [3];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_out(input bit ev, input logic [15:0] ep);
    chk("pixValid", {31'd0, bus.pixValid}, {31'd0, ev});
    if (ev) begin
      chk("pixOut",    {16'd0, bus.pixOut},   {16'd0, ep});
      chk("outCount",  {8'd0, bus.outCount},  exp_cnt);
      chk("frameDone", {31'd0, bus.frameDone}, (exp_cnt == 11) ? 32'd1 : 32'd0);
      exp_cnt = (exp_cnt == 11) ? 0 : exp_cnt + 1;
    end else begin
      chk("frameDone_idle", {31'd0, bus.frameDone}, 32'd0);
    end
  endtask

  // kind 0: all 15 pixels = val; kind 1: only C col1 = val
  task automatic drive(input bit wv, input int kind, input logic [15:0] val);
    bus.winValid = wv;
    if (kind == 0) begin
      bus.gausShiftOutA = {val, val, val};
      bus.gausShiftOutB = {val, val, val};
      bus.gausShiftOutC = {val, val, val};
      bus.gausShiftOutD = {val, val, val};
      bus.gausShiftOutE = {val, val, val};
    end else begin
      bus.gausShiftOutA = '0;
      bus.gausShiftOutB = '0;
      bus.gausShiftOutC = {16'd0, val, 16'd0};
      bus.gausShiftOutD = '0;
      bus.gausShiftOutE = '0;
    end
  endtask

  // One cycle: check what is due now, then present a beat whose result is due 3 cycles later.
  task automatic cyc(input bit wv, input int kind, input logic [15:0] val,
                     input bit ev, input logic [15:0] epix);
    @(negedge clk);
    check_out(d_v[2], d_p[2]);
    d_v[2] = d_v[1]; d_p[2] = d_p[1];
    d_v[1] = d_v[0]; d_p[1] = d_p[0];
    d_v[0] = ev;     d_p[0] = epix;
    drive(wv, kind, val);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 16'd0, 1'b0, 16'd0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pixValid"},  {31'd0, bus.pixValid},  32'd0);
    chk({tag, "_pixOut"},    {16'd0, bus.pixOut},    32'd0);
    chk({tag, "_outCount"},  {8'd0, bus.outCount},   32'd0);
    chk({tag, "_frameDone"}, {31'd0, bus.frameDone}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin d_v[i] = 1'b0; d_p[i] = '0; end
    reset = 1'b0;
    drive(1'b0, 0, 16'd0);
    repeat (2) @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    // Flat field 100: first two beats of the line are warm-up
    for (int i = 0; i < 8; i++) cyc(1'b1, 0, 16'd100, i >= 2, 16'd100);
    idle(3);

    // Impulse / rounding / full-scale line; last output closes the frame (index 11)
    cyc(1'b1, 1, 16'd64,    1'b0, 16'd0);
    cyc(1'b1, 1, 16'd64,    1'b0, 16'd0);
    cyc(1'b1, 1, 16'd64,    1'b1, 16'd12);
    cyc(1'b1, 1, 16'd1,     1'b1, 16'd0);
    cyc(1'b1, 1, 16'd8,     1'b1, 16'd2);
    cyc(1'b1, 1, 16'd2,     1'b1, 16'd0);
    cyc(1'b1, 0, 16'd65535, 1'b1, 16'd65535);
    cyc(1'b1, 0, 16'd100,   1'b1, 16'd100);
    idle(3);

    // Frame wrap: 16 back-to-back beats -> 12 pixels, frameDone on index 11
    for (int i = 0; i < 16; i++) cyc(1'b1, 0, 16'd7, (i % 8) >= 2, 16'd7);
    // Continue straight on: the 3rd beat lands on the frameDone cycle and restarts at position 0
    for (int i = 0; i < 10; i++) cyc(1'b1, 0, 16'd9, i >= 4, 16'd9);
    idle(3);

    // Reset with two valid beats in flight
    cyc(1'b1, 0, 16'd50, 1'b0, 16'd0);
    cyc(1'b1, 0, 16'd50, 1'b0, 16'd0);
    cyc(1'b1, 0, 16'd50, 1'b0, 16'd0);
    cyc(1'b1, 0, 16'd50, 1'b0, 16'd0);
    @(negedge clk);
    check_out(d_v[2], d_p[2]);
    reset = 1'b0;
    drive(1'b0, 0, 16'd0);
    #1;
    chk_zero("midreset");
    for (int i = 0; i < 3; i++) begin d_v[i] = 1'b0; d_p[i] = '0; end
    exp_cnt = 0;
    @(negedge clk);
    chk("midreset_flush", {31'd0, bus.pixValid}, 32'd0);
    reset = 1'b1;
    idle(2);
    for (int i = 0; i < 8; i++) cyc(1'b1, 0, 16'd50, i >= 2, 16'd50);
    idle(4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
